// File: rtl/memory_sequencer.sv
// Memory-stage sequencer: passes single loads/stores through and expands CALL, RET,
// RTI and interrupt entry into 16-bit push/pop/read sequences, stalling the pipeline meanwhile.
module memory_sequencer #(
   parameter logic [15:0] INT_VECTOR_ADDR = 16'h0000,
   parameter int          FLAG_W          = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [15:0]       ex_address,
   input  logic [15:0]       ex_write_data,
   input  logic              op_call,
   input  logic              op_ret,
   input  logic              op_rti,
   input  logic              int_req,
   input  logic [31:0]       pc_ret,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic [15:0]       mem_data,
   output logic              memory_read,
   output logic              memory_write,
   output logic              memory_push,
   output logic              memory_pop,
   output logic [15:0]       address,
   output logic [15:0]       write_data,
   output logic              stall,
   output logic              pc_load,
   output logic [31:0]       pc_out,
   output logic              flags_load,
   output logic [FLAG_W-1:0] flags_out,
   output logic              int_ack,
   output logic [3:0]        state_o
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_PUSH_HI    = 4'd1,
      S_PUSH_LO    = 4'd2,
      S_PUSH_FLAGS = 4'd3,
      S_VEC_HI     = 4'd4,
      S_VEC_LO     = 4'd5,
      S_POP_FLAGS  = 4'd6,
      S_POP_LO     = 4'd7,
      S_POP_HI     = 4'd8,
      S_LOAD       = 4'd9
   } state_t;

   state_t            state_q;
   logic [31:0]       pc_q;
   logic [FLAG_W-1:0] flags_q;
   logic [15:0]       word_q;
   logic              is_int_q;
   logic              is_rti_q;
   logic [31:0]       pc_out_q;
   logic [FLAG_W-1:0] flags_out_q;

   logic start;
   logic sel_int;

   // Stall acts as the pipeline's ready: while stall=1 the op_* and pc_ret/flags_in
   // inputs are held upstream; a request is taken only in the IDLE cycle where stall rises.
   assign start   = op_rti | op_ret | op_call | int_req;
   assign sel_int = int_req & ~(op_rti | op_ret | op_call);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         flags_q     <= '0;
         word_q      <= '0;
         is_int_q    <= 1'b0;
         is_rti_q    <= 1'b0;
         pc_out_q    <= '0;
         flags_out_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_q     <= pc_ret;
                  flags_q  <= flags_in;
                  is_int_q <= sel_int;
                  is_rti_q <= op_rti;
                  if (op_rti)      state_q <= S_POP_FLAGS;
                  else if (op_ret) state_q <= S_POP_LO;
                  else             state_q <= S_PUSH_HI;
               end
            end
            S_PUSH_HI: state_q <= S_PUSH_LO;
            S_PUSH_LO: begin
               pc_out_q <= pc_q;
               state_q  <= is_int_q ? S_PUSH_FLAGS : S_LOAD;
            end
            S_PUSH_FLAGS: state_q <= S_VEC_HI;
            S_VEC_HI: begin
               word_q  <= mem_data;
               state_q <= S_VEC_LO;
            end
            S_VEC_LO: begin
               pc_out_q <= {word_q, mem_data};
               state_q  <= S_LOAD;
            end
            S_POP_FLAGS: begin
               flags_out_q <= mem_data[FLAG_W-1:0];
               state_q     <= S_POP_LO;
            end
            S_POP_LO: begin
               word_q  <= mem_data;
               state_q <= S_POP_HI;
            end
            S_POP_HI: begin
               pc_out_q <= {mem_data, word_q};
               state_q  <= S_LOAD;
            end
            S_LOAD:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Reset gates every command combinationally so nothing leaks while rst_n is low.
   always_comb begin
      memory_read  = 1'b0;
      memory_write = 1'b0;
      memory_push  = 1'b0;
      memory_pop   = 1'b0;
      address      = '0;
      write_data   = '0;
      stall        = 1'b0;
      pc_load      = 1'b0;
      flags_load   = 1'b0;
      int_ack      = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  stall   = 1'b1;
                  int_ack = sel_int;
               end else begin
                  memory_read  = ex_mem_read;
                  memory_write = ex_mem_write;
                  address      = ex_address;
                  write_data   = ex_write_data;
               end
            end
            S_PUSH_HI: begin
               stall       = 1'b1;
               memory_push = 1'b1;
               write_data  = pc_q[31:16];
            end
            S_PUSH_LO: begin
               stall       = 1'b1;
               memory_push = 1'b1;
               write_data  = pc_q[15:0];
            end
            S_PUSH_FLAGS: begin
               stall       = 1'b1;
               memory_push = 1'b1;
               write_data  = {{(16-FLAG_W){1'b0}}, flags_q};
            end
            S_VEC_HI: begin
               stall       = 1'b1;
               memory_read = 1'b1;
               address     = INT_VECTOR_ADDR;
            end
            S_VEC_LO: begin
               stall       = 1'b1;
               memory_read = 1'b1;
               address     = INT_VECTOR_ADDR + 16'd1;
            end
            S_POP_FLAGS, S_POP_LO, S_POP_HI: begin
               stall      = 1'b1;
               memory_pop = 1'b1;
            end
            S_LOAD: begin
               pc_load    = 1'b1;
               flags_load = is_rti_q;
            end
            default: ;
         endcase
      end
   end

   assign pc_out    = pc_out_q;
   assign flags_out = flags_out_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: directed scenarios plus random operation mix, checked
// cycle by cycle against a word-level stack model and expected-command queue.
module tb_memory_sequencer;

   localparam logic [15:0] VEC = 16'h0000;
   localparam int K_CALL = 0, K_INT = 1, K_RET = 2, K_RTI = 3;

   typedef struct packed {
      logic stall, rd, wr, push, pop, pcl, fll, ack;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cyc_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic ex_mem_read = 0, ex_mem_write = 0;
   logic [15:0] ex_address = '0, ex_write_data = '0;
   logic op_call = 0, op_ret = 0, op_rti = 0, int_req = 0;
   logic [31:0] pc_ret = '0;
   logic [2:0] flags_in = '0;
   logic [15:0] mem_data;
   logic memory_read, memory_write, memory_push, memory_pop;
   logic [15:0] address, write_data;
   logic stall, pc_load, flags_load, int_ack;
   logic [31:0] pc_out;
   logic [2:0] flags_out;
   logic [3:0] state_o;

   memory_sequencer #(.INT_VECTOR_ADDR(VEC), .FLAG_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_address(ex_address), .ex_write_data(ex_write_data),
      .op_call(op_call), .op_ret(op_ret), .op_rti(op_rti), .int_req(int_req),
      .pc_ret(pc_ret), .flags_in(flags_in), .mem_data(mem_data),
      .memory_read(memory_read), .memory_write(memory_write),
      .memory_push(memory_push), .memory_pop(memory_pop),
      .address(address), .write_data(write_data), .stall(stall),
      .pc_load(pc_load), .pc_out(pc_out), .flags_load(flags_load),
      .flags_out(flags_out), .int_ack(int_ack), .state_o(state_o)
   );

   // clock / reset
   always #5 clk = ~clk;

   // memory-stage environment: a hardware stack plus a small vector table
   logic [15:0] env_stk [0:255];
   logic [7:0]  env_sp = '0;
   logic [15:0] vmem0 = '0, vmem1 = '0;

   always_comb begin
      mem_data = '0;
      if (memory_pop) mem_data = env_stk[env_sp - 8'd1];
      else if (memory_read) begin
         if (address == VEC)              mem_data = vmem0;
         else if (address == VEC + 16'd1) mem_data = vmem1;
         else                             mem_data = address ^ 16'hA5A5;
      end
   end

   always @(posedge clk) begin
      if (memory_push) begin
         env_stk[env_sp] <= write_data;
         env_sp <= env_sp + 8'd1;
      end else if (memory_pop) begin
         env_sp <= env_sp - 8'd1;
      end
   end

   // scoreboard
   int n_cmp = 0, n_err = 0;
   cyc_t exp_q[$];
   logic [15:0] stk_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic cyc_t c_start(input logic ack);
      return cyc_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ack, 16'h0, 16'h0};
   endfunction
   function automatic cyc_t c_push(input logic [15:0] w);
      return cyc_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, w};
   endfunction
   function automatic cyc_t c_pop();
      return cyc_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0};
   endfunction
   function automatic cyc_t c_read(input logic [15:0] a);
      return cyc_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, a, 16'h0};
   endfunction
   function automatic cyc_t c_load(input logic fl);
      return cyc_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fl, 1'b0, 16'h0, 16'h0};
   endfunction

   task automatic check_cycle(input string tag, input cyc_t e);
      check({tag, ".ctl"},
            {stall, memory_read, memory_write, memory_push, memory_pop, pc_load, flags_load, int_ack},
            {e.stall, e.rd, e.wr, e.push, e.pop, e.pcl, e.fll, e.ack});
      if (e.rd || e.wr) check({tag, ".addr"}, address, e.addr);
      if (e.wr || e.push) check({tag, ".wdata"}, write_data, e.wdata);
   endtask

   // driver: one pass-through cycle from IDLE
   task automatic pass_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
      ex_mem_read = rd; ex_mem_write = wr; ex_address = a; ex_write_data = d;
      @(negedge clk);
      check("pass.ctl",
            {stall, memory_read, memory_write, memory_push, memory_pop, pc_load, flags_load, int_ack},
            {1'b0, rd, wr, 5'b0});
      check("pass.addr", address, a);
      check("pass.wdata", write_data, d);
      @(posedge clk); #1;
      ex_mem_read = 0; ex_mem_write = 0; ex_address = '0; ex_write_data = '0;
   endtask

   // driver: full sequence; int_req is high on cycle indices [int_on, int_off)
   task automatic run_op(input int kind, input logic [31:0] pc, input logic [2:0] fl,
                         input int int_on, input int int_off);
      logic [31:0] exp_pc;
      logic [2:0]  exp_fl;
      logic [15:0] w_hi, w_lo, w_f;
      int n;
      string tag;
      exp_q = {};
      exp_fl = '0;
      exp_pc = '0;
      pc_ret = pc; flags_in = fl;
      case (kind)
         K_CALL: begin
            exp_q.push_back(c_start(1'b0));
            exp_q.push_back(c_push(pc[31:16]));
            exp_q.push_back(c_push(pc[15:0]));
            exp_q.push_back(c_load(1'b0));
            stk_q.push_back(pc[31:16]); stk_q.push_back(pc[15:0]);
            exp_pc = pc; op_call = 1; tag = "call";
         end
         K_INT: begin
            exp_q.push_back(c_start(1'b1));
            exp_q.push_back(c_push(pc[31:16]));
            exp_q.push_back(c_push(pc[15:0]));
            exp_q.push_back(c_push({13'b0, fl}));
            exp_q.push_back(c_read(VEC));
            exp_q.push_back(c_read(VEC + 16'd1));
            exp_q.push_back(c_load(1'b0));
            stk_q.push_back(pc[31:16]); stk_q.push_back(pc[15:0]); stk_q.push_back({13'b0, fl});
            exp_pc = {vmem0, vmem1}; tag = "int";
         end
         K_RET: begin
            w_lo = stk_q.pop_back(); w_hi = stk_q.pop_back();
            exp_q.push_back(c_start(1'b0));
            exp_q.push_back(c_pop()); exp_q.push_back(c_pop());
            exp_q.push_back(c_load(1'b0));
            exp_pc = {w_hi, w_lo}; op_ret = 1; op_call = 1'($urandom_range(0, 1)); tag = "ret";
         end
         default: begin
            w_f = stk_q.pop_back(); w_lo = stk_q.pop_back(); w_hi = stk_q.pop_back();
            exp_q.push_back(c_start(1'b0));
            exp_q.push_back(c_pop()); exp_q.push_back(c_pop()); exp_q.push_back(c_pop());
            exp_q.push_back(c_load(1'b1));
            exp_pc = {w_hi, w_lo}; exp_fl = w_f[2:0];
            op_rti = 1; op_ret = 1'($urandom_range(0, 1)); op_call = 1'($urandom_range(0, 1));
            tag = "rti";
         end
      endcase
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         int_req = (i >= int_on) && (i < int_off);
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_mem_write = 1'($urandom_range(0, 1));
         ex_address = 16'($urandom); ex_write_data = 16'($urandom);
         @(negedge clk);
         check_cycle($sformatf("%s.c%0d", tag, i), exp_q[i]);
         if (i == n - 1) begin
            check({tag, ".pc_out"}, pc_out, exp_pc);
            if (kind == K_RTI) check({tag, ".flags_out"}, flags_out, exp_fl);
         end
         @(posedge clk); #1;
         if (i == 0) begin
            pc_ret = $urandom; flags_in = 3'($urandom_range(0, 7));
         end
      end
      op_call = 0; op_ret = 0; op_rti = 0;
      ex_mem_read = 0; ex_mem_write = 0; ex_address = '0; ex_write_data = '0;
      int_req = (n >= int_on) && (n < int_off);
   endtask

   initial begin
      logic [31:0] pc;
      // reset state, with live pass-through inputs that must be gated
      ex_mem_write = 1; ex_address = 16'h1234; ex_write_data = 16'h5678; op_call = 1;
      #12;
      check("rst.ctl",
            {stall, memory_read, memory_write, memory_push, memory_pop, pc_load, flags_load, int_ack}, 8'h00);
      check("rst.addr", address, 16'h0);
      check("rst.wdata", write_data, 16'h0);
      check("rst.pc_out", pc_out, 32'h0);
      check("rst.flags_out", flags_out, 3'h0);
      ex_mem_write = 0; ex_address = '0; ex_write_data = '0; op_call = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      pass_op(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      run_op(K_CALL, 32'h0001_2345, 3'b000, 99, 99);
      run_op(K_RET, 32'h0, 3'b000, 99, 99);
      pass_op(1'b1, 1'b0, 16'h0042, 16'h0000);

      vmem0 = 16'h0000; vmem1 = 16'h0100;
      run_op(K_INT, 32'h0000_0050, 3'b101, 0, 1);
      run_op(K_RTI, 32'h0, 3'b000, 99, 99);

      // CALL wins over a simultaneous interrupt; interrupt taken right after LOAD
      run_op(K_CALL, 32'hCAFE_0010, 3'b010, 0, 99);
      vmem0 = 16'hABCD; vmem1 = 16'hFFFF;
      run_op(K_INT, 32'h1111_2222, 3'b011, 0, 1);
      // interrupt raised during POP_LO of a RET is held off until after LOAD
      run_op(K_RET, 32'h0, 3'b000, 1, 99);
      run_op(K_INT, 32'h3333_4444, 3'b110, 0, 1);

      // asynchronous reset during PUSH_LO
      pc = 32'h7777_8888;
      op_call = 1; pc_ret = pc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 0; #1;
      check("rstmid.ctl",
            {stall, memory_read, memory_write, memory_push, memory_pop, pc_load, flags_load, int_ack}, 8'h00);
      check("rstmid.wdata", write_data, 16'h0);
      check("rstmid.pc_out", pc_out, 32'h0);
      stk_q.push_back(pc[31:16]);
      op_call = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      pass_op(1'b0, 1'b1, 16'h00FF, 16'h1357);

      // random operation mix
      for (int it = 0; it < 80; it++) begin
         int r;
         r = $urandom_range(0, 5);
         if (r == 4 && stk_q.size() >= 2) begin
            if ($urandom_range(0, 3) == 0) begin
               run_op(K_RET, 32'h0, 3'b0, $urandom_range(1, 3), 99);
               vmem0 = 16'($urandom); vmem1 = 16'($urandom);
               run_op(K_INT, $urandom, 3'($urandom_range(0, 7)), 0, 1);
            end else run_op(K_RET, 32'h0, 3'b0, 99, 99);
         end else if (r == 5 && stk_q.size() >= 3) begin
            run_op(K_RTI, 32'h0, 3'b0, 99, 99);
         end else if (r == 2 && stk_q.size() < 240) begin
            run_op(K_CALL, $urandom, 3'($urandom_range(0, 7)), 99, 99);
         end else if (r == 3 && stk_q.size() < 240) begin
            vmem0 = 16'($urandom); vmem1 = 16'($urandom);
            run_op(K_INT, $urandom, 3'($urandom_range(0, 7)), 0, 1);
         end else begin
            pass_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
